key_expansion: RTL

//  Iterative AES-128 round-key generator; feeds the AddRoundKey stage that consumes Mix_Column output.

---
 rtl/key_expansion.sv | 107 ++++++++++
 1 files changed

// File: rtl/key_expansion.sv
// Iterative AES-128 round-key generator. One round key per rk_next through a READY->CALC->UPDATE walk.
// SubWord is performed by a shared external S-box fed from sbox_in.
module key_expansion #(
    parameter int unsigned N  = 8,
    parameter int unsigned NR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [16*N-1:0]   key_in,
    input  logic              rk_next,
    input  logic [4*N-1:0]    sbox_out,
    output logic [4*N-1:0]    sbox_in,
    output logic [16*N-1:0]   rk_out,
    output logic [3:0]        rk_round,
    output logic              rk_valid,
    output logic              busy
);

    localparam int unsigned WW = 4 * N;
    localparam int unsigned KW = 16 * N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        CALC   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [KW-1:0]   r_rk;
    logic [3:0]      r_round;
    logic [N-1:0]    r_rcon;
    logic [WW-1:0]   r_sub;
    logic            r_valid;
    logic            r_busy;

    logic [WW-1:0]   w_t;
    logic [WW-1:0]   w_w0;
    logic [WW-1:0]   w_w1;
    logic [WW-1:0]   w_w2;
    logic [WW-1:0]   w_w3;
    logic [N-1:0]    w_rcon_nxt;
    logic [KW-1:0]   w_rk_upd;

    // Next-state logic; key_load overrides everything, including an in-flight round.
    always_comb begin
        w_state_nxt = r_state;
        if (key_load) begin
            w_state_nxt = READY;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                READY:   if (rk_next && (r_round < 4'(NR))) w_state_nxt = CALC;
                CALC:    w_state_nxt = UPDATE;
                UPDATE:  w_state_nxt = READY;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Round-key update from the captured SubWord(RotWord(w3)) and current rcon.
    always_comb begin
        w_t        = r_sub ^ {r_rcon, {(3*N){1'b0}}};
        w_w0       = r_rk[KW-1 -: WW] ^ w_t;
        w_w1       = r_rk[3*WW-1 -: WW] ^ w_w0;
        w_w2       = r_rk[2*WW-1 -: WW] ^ w_w1;
        w_w3       = r_rk[WW-1 -: WW] ^ w_w2;
        w_rk_upd   = {w_w0, w_w1, w_w2, w_w3};
        w_rcon_nxt = {r_rcon[N-2:0], 1'b0} ^ (r_rcon[N-1] ? N'(8'h1b) : N'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rk    <= '0;
            r_round <= 4'd0;
            r_rcon  <= N'(8'h01);
            r_sub   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == READY);
            r_busy  <= (w_state_nxt == CALC) || (w_state_nxt == UPDATE);
            if (key_load) begin
                r_rk    <= key_in;
                r_round <= 4'd0;
                r_rcon  <= N'(8'h01);
            end else if (r_state == CALC) begin
                r_sub   <= sbox_out;
            end else if (r_state == UPDATE) begin
                r_rk    <= w_rk_upd;
                r_round <= r_round + 4'd1;
                r_rcon  <= w_rcon_nxt;
            end
        end
    end

    assign sbox_in  = {r_rk[WW-N-1:0], r_rk[WW-1 -: N]};
    assign rk_out   = r_rk;
    assign rk_round = r_round;
    assign rk_valid = r_valid;
    assign busy     = r_busy;

endmodule
